// File: rtl/call_ret_seq_pkg.sv
// ============================================================================
// Module   : call_ret_seq_pkg
// Purpose  : Shared processor definitions: opcodes, sequencer states and
//            request kinds used by the CALL/RET/INT/RTI stack sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package call_ret_seq_pkg;

    localparam logic [5:0] OP_CALL = 6'h30;
    localparam logic [5:0] OP_RET  = 6'h31;
    localparam logic [5:0] OP_INT  = 6'h32;
    localparam logic [5:0] OP_RTI  = 6'h33;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        PUSH_HI  = 4'd1,
        PUSH_LO  = 4'd2,
        PUSH_FLG = 4'd3,
        POP_FLG  = 4'd4,
        POP_LO   = 4'd5,
        POP_HI   = 4'd6,
        VEC_LO   = 4'd7,
        VEC_HI   = 4'd8,
        DONE     = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        KIND_CALL = 2'd0,
        KIND_RET  = 2'd1,
        KIND_INT  = 2'd2,
        KIND_RTI  = 2'd3
    } req_kind_t;

    // CALL and INT save the return PC and jump to a fresh target
    function automatic logic kind_pushes(input req_kind_t k);
        return (k == KIND_CALL) || (k == KIND_INT);
    endfunction

endpackage

`default_nettype wire

// File: rtl/call_ret_seq_stack_addr_unit.sv
// ============================================================================
// Module   : stack_addr_unit
// Purpose  : Stack pointer register with +/-1 update and stack address select
//            (pushes address SP, pops address SP+1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module stack_addr_unit #(
    parameter logic [31:0] RST_SP = 32'h000F_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec,
    input  logic        inc,
    input  logic        pop_sel,
    output logic [31:0] sp,
    output logic [31:0] addr
);

    logic [31:0] r_sp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp <= RST_SP;
        end else if (dec) begin
            r_sp <= r_sp - 32'd1;
        end else if (inc) begin
            r_sp <= r_sp + 32'd1;
        end
    end

    assign sp   = r_sp;
    assign addr = pop_sel ? (r_sp + 32'd1) : r_sp;

endmodule

`default_nettype wire

// File: rtl/call_ret_seq.sv
// ============================================================================
// Module   : call_ret_seq
// Purpose  : Multi-cycle sequencer for CALL/RET/INT/RTI stack traffic,
//            stalling the pipeline until the PC load in DONE.
// Revision : 1.0
// ============================================================================
`default_nettype none

module call_ret_seq
    import call_ret_seq_pkg::*;
#(
    parameter logic [31:0] RST_SP       = 32'h000F_FFFF,
    parameter logic [31:0] INT_VEC_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        call_req,
    input  logic        ret_req,
    input  logic        int_req,
    input  logic        rti_req,
    input  logic [31:0] pc_in,
    input  logic [31:0] target_in,
    input  logic [2:0]  flags_in,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] sp_out,
    output logic [31:0] pc_out,
    output logic        pc_we,
    output logic [2:0]  flags_out,
    output logic        flags_we,
    output logic        stall
);

    state_t      r_state;
    state_t      w_next;
    req_kind_t   r_kind;
    req_kind_t   w_kind;
    logic        w_accept;
    logic [31:0] r_pc;
    logic [31:0] r_target;
    logic [2:0]  r_flags;
    logic        w_sp_dec;
    logic        w_sp_inc;
    logic        w_pop_sel;
    logic [31:0] w_stack_addr;

    stack_addr_unit #(
        .RST_SP (RST_SP)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .dec     (w_sp_dec),
        .inc     (w_sp_inc),
        .pop_sel (w_pop_sel),
        .sp      (sp_out),
        .addr    (w_stack_addr)
    );

    always_comb begin
        w_accept = int_req | call_req | rti_req | ret_req;
        if (int_req) begin
            w_kind = KIND_INT;
        end else if (call_req) begin
            w_kind = KIND_CALL;
        end else if (rti_req) begin
            w_kind = KIND_RTI;
        end else begin
            w_kind = KIND_RET;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Target doubles as the vector holder; PC doubles as the popped return PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kind   <= KIND_CALL;
            r_pc     <= 32'd0;
            r_target <= 32'd0;
            r_flags  <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_kind   <= w_kind;
                        r_pc     <= pc_in;
                        r_target <= target_in;
                        r_flags  <= flags_in;
                    end
                end
                POP_FLG: if (mem_ready) r_flags         <= mem_rdata[2:0];
                POP_LO:  if (mem_ready) r_pc[15:0]      <= mem_rdata;
                POP_HI:  if (mem_ready) r_pc[31:16]     <= mem_rdata;
                VEC_LO:  if (mem_ready) r_target[15:0]  <= mem_rdata;
                VEC_HI:  if (mem_ready) r_target[31:16] <= mem_rdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_addr  = 32'd0;
        mem_wdata = 16'd0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pc_out    = 32'd0;
        pc_we     = 1'b0;
        flags_out = 3'd0;
        flags_we  = 1'b0;
        stall     = 1'b1;
        w_sp_dec  = 1'b0;
        w_sp_inc  = 1'b0;
        w_pop_sel = 1'b0;
        case (r_state)
            IDLE: begin
                // Requests may be held high during reset; keep stall quiet then
                stall = w_accept & rst_n;
                if (w_accept) begin
                    if (kind_pushes(w_kind)) begin
                        w_next = PUSH_HI;
                    end else if (w_kind == KIND_RTI) begin
                        w_next = POP_FLG;
                    end else begin
                        w_next = POP_LO;
                    end
                end
            end
            PUSH_HI: begin
                mem_write = 1'b1;
                mem_addr  = w_stack_addr;
                mem_wdata = r_pc[31:16];
                w_sp_dec  = mem_ready;
                if (mem_ready) w_next = PUSH_LO;
            end
            PUSH_LO: begin
                mem_write = 1'b1;
                mem_addr  = w_stack_addr;
                mem_wdata = r_pc[15:0];
                w_sp_dec  = mem_ready;
                if (mem_ready) w_next = (r_kind == KIND_INT) ? PUSH_FLG : DONE;
            end
            PUSH_FLG: begin
                mem_write = 1'b1;
                mem_addr  = w_stack_addr;
                mem_wdata = {13'd0, r_flags};
                w_sp_dec  = mem_ready;
                if (mem_ready) w_next = VEC_LO;
            end
            VEC_LO: begin
                mem_read = 1'b1;
                mem_addr = INT_VEC_ADDR;
                if (mem_ready) w_next = VEC_HI;
            end
            VEC_HI: begin
                mem_read = 1'b1;
                mem_addr = INT_VEC_ADDR + 32'd1;
                if (mem_ready) w_next = DONE;
            end
            POP_FLG: begin
                mem_read  = 1'b1;
                w_pop_sel = 1'b1;
                mem_addr  = w_stack_addr;
                w_sp_inc  = mem_ready;
                if (mem_ready) w_next = POP_LO;
            end
            POP_LO: begin
                mem_read  = 1'b1;
                w_pop_sel = 1'b1;
                mem_addr  = w_stack_addr;
                w_sp_inc  = mem_ready;
                if (mem_ready) w_next = POP_HI;
            end
            POP_HI: begin
                mem_read  = 1'b1;
                w_pop_sel = 1'b1;
                mem_addr  = w_stack_addr;
                w_sp_inc  = mem_ready;
                if (mem_ready) w_next = DONE;
            end
            DONE: begin
                pc_we  = 1'b1;
                pc_out = kind_pushes(r_kind) ? r_target : r_pc;
                if (r_kind == KIND_RTI) begin
                    flags_we  = 1'b1;
                    flags_out = r_flags;
                end
                w_next = IDLE;
            end
            default: begin
                stall  = 1'b0;
                w_next = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: doc/call_ret_seq.md
CALL_RET_SEQ -- requirements
Module: call_ret_seq

Interface
REQ-001 SHALL have parameter RST_SP, default 32'h000F_FFFF, meaning the stack-pointer value restored on reset.
REQ-002 SHALL have parameter INT_VEC_ADDR, default 32'h0000_0000, meaning the data-memory address of the low word of the interrupt vector; the high word is at INT_VEC_ADDR+1.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, exactly as ports clk and rst_n below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 call_req / ret_req / int_req / rti_req  in  1 each  single-cycle requests from the decode/execute stage.
REQ-007 pc_in  in  32  return PC to save; target_in  in  32  CALL target.
REQ-008 flags_in  in  3  {C,N,Z} to save on interrupt.
REQ-009 mem_rdata  in  16  read data; mem_ready  in  1  memory completes the current access this cycle.
REQ-010 mem_addr  out  32; mem_wdata  out  16; mem_read  out  1; mem_write  out  1  data-memory port.
REQ-011 sp_out  out  32  current stack pointer.
REQ-012 pc_out  out  32; pc_we  out  1  PC load to fetch.
REQ-013 flags_out  out  3; flags_we  out  1  flag restore.
REQ-014 stall  out  1  freeze the IF/ID/EX stages.

Function
REQ-015 The FSM SHALL use the states IDLE, PUSH_HI, PUSH_LO, PUSH_FLG, POP_FLG, POP_LO, POP_HI, VEC_LO, VEC_HI and DONE.
REQ-016 Requests SHALL be sampled only in IDLE, with priority int > call > rti > ret; lower-priority simultaneous requests are dropped.
REQ-017 The PC and target SHALL be captured on the accepting edge.
REQ-018 The paths SHALL be:
- CALL: IDLE->PUSH_HI->PUSH_LO->DONE.
- INT: IDLE->PUSH_HI->PUSH_LO->PUSH_FLG->VEC_LO->VEC_HI->DONE.
- RET: IDLE->POP_LO->POP_HI->DONE.
- RTI: IDLE->POP_FLG->POP_LO->POP_HI->DONE.
REQ-019 A push SHALL write mem[SP] then decrement SP; a pop SHALL increment SP then read mem[SP+1]. SP arithmetic is modulo 2^32.
REQ-020 PUSH_HI SHALL write pc[31:16] and PUSH_LO SHALL write pc[15:0]. PUSH_FLG SHALL write {13'b0,flags}. Pops SHALL restore in reverse order.
REQ-021 Each memory state SHALL hold mem_addr, mem_wdata and the strobe stable until mem_ready=1, and SHALL advance on that edge. At most one of mem_read and mem_write is high at any time.
REQ-022 The SP update for a push or pop SHALL occur on the edge where mem_ready=1, never earlier.
REQ-023 DONE SHALL last exactly one cycle:
- pc_we=1, with pc_out = target (CALL), the vector (INT) or the popped PC (RET/RTI).
- flags_we=1 only for RTI, with flags_out = mem word [2:0].
- DONE then returns to IDLE.
REQ-024 stall SHALL be combinationally high in an accepted request cycle, and SHALL stay high through DONE inclusive.
REQ-025 With mem_ready tied high, latency from the accepting edge to pc_we SHALL be: CALL 3 cycles, RET 3, RTI 4, INT 6.
REQ-026 Requests arriving while not in IDLE SHALL be ignored, because upstream is stalled.

Reset
REQ-027 When rst_n=0, the block SHALL asynchronously force:
- state=IDLE, sp_out=RST_SP.
- mem_read, mem_write, pc_we, flags_we and stall = 0.
- mem_addr, mem_wdata, pc_out and flags_out = 0.
REQ-028 A reset mid-sequence SHALL abort it with no further memory strobe, and SHALL leave SP at RST_SP and not at the partially updated value.

Structure
REQ-029 The state encoding and the request-kind encoding SHALL live in the shared processor package alongside the opcode constants.
REQ-030 A single sub-module, stack_addr_unit (SP register plus ±1 adder and address select), is natural.
REQ-031 The FSM SHALL remain in call_ret_seq.

Verification
REQ-032 With SP=RST_SP, call_req, pc_in=32'h0001_0024, target_in=32'h0000_0100 and mem_ready=1, the bench SHALL check:
- writes 16'h0001 to 0xFFFFF, then 16'h0024 to 0xFFFFE.
- pc_we with pc_out=0x100 on cycle 3.
- sp_out=0xFFFFD.
REQ-033 Following REQ-032, ret_req SHALL read 0xFFFFE then 0xFFFFF, load pc_out=0x0001_0024 and restore sp_out=0xFFFFF.
REQ-034 With int_req and call_req in the same cycle, flags_in=3'b101, mem[0]=16'h0200 and mem[1]=16'h0000, the bench SHALL check:
- the INT path runs and the CALL is dropped.
- word 0x0005 is pushed third.
- pc_out=0x0000_0200 on cycle 6.
REQ-035 With mem_ready held low for 4 cycles during PUSH_LO, the bench SHALL check:
- address and data stay stable and stall stays high.
- SP decrements only on the ready edge.
REQ-036 Deasserting rst_n during PUSH_LO SHALL give immediate IDLE, no strobes and sp_out=RST_SP.
REQ-037 With SP=0, a CALL SHALL write to address 0 then 0xFFFFFFFF and leave sp_out=0xFFFFFFFE (wrap).
